// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers and defaults for buffer blocks.
// Ports: none (package).
package sync_fifo_ctrl_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_ADDR_WIDTH = 4;

  function automatic int fifo_depth(int aw);
    return 1 << aw;
  endfunction

  function automatic int fifo_cnt_w(int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port, registered read.
// Ports: Clock, Reset, we/waddr/wdata, re/raddr, rdata.
module fifo_sdp_ram
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read register holds when not enabled
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy and flags around an SDP RAM.
// Ports: Clock, Reset, iClear, iPush/iDataIn, iPop, oDataOut/oDataValid,
//        oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount,
//        oOverflow, oUnderflow.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH         = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH         = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iClear,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic                  iPop,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oDataValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = fifo_cnt_w(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_nxt, rd_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;

  logic push_ok, pop_ok;
  logic ov_nxt, un_nxt;

  // accept decisions use pre-edge flags only;
  // a flush suppresses every request
  assign push_ok = iPush & ~oFull & ~iClear;
  assign pop_ok  = iPop & ~oEmpty & ~iClear;

  always_comb begin
    wr_nxt  = wr_ptr;
    rd_nxt  = rd_ptr;
    cnt_nxt = cnt;
    ov_nxt  = 1'b0;
    un_nxt  = 1'b0;
    if (iClear) begin
      wr_nxt  = '0;
      rd_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      ov_nxt = iPush & oFull;
      un_nxt = iPop & oEmpty;
      if (push_ok) begin
        wr_nxt = wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_nxt = rd_ptr + PTR_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_nxt = cnt + CNT_ONE;
        2'b01:   cnt_nxt = cnt - CNT_ONE;
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      oDataValid   <= 1'b0;
      oOverflow    <= 1'b0;
      oUnderflow   <= 1'b0;
      oFull        <= 1'b0;
      oEmpty       <= 1'b1;
      oAlmostFull  <= 1'b0;
      oAlmostEmpty <= 1'b1;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      cnt          <= cnt_nxt;
      oDataValid   <= pop_ok;
      oOverflow    <= ov_nxt;
      oUnderflow   <= un_nxt;
      oFull        <= (cnt_nxt == DEPTH_C);
      oEmpty       <= (cnt_nxt == '0);
      oAlmostFull  <= (cnt_nxt >= AF_C);
      oAlmostEmpty <= (cnt_nxt <= AE_C);
    end
  end

  assign oCount = cnt;

  // read port only advances on an accepted pop,
  // so a flush leaves the last word on oDataOut
  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .Clock (Clock),
    .Reset (Reset),
    .we    (push_ok & ~Reset),
    .waddr (wr_ptr),
    .wdata (iDataIn),
    .re    (pop_ok & ~Reset),
    .raddr (rd_ptr),
    .rdata (oDataOut)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (default parameters).
// Ports: none.
module tb_sync_fifo_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iClear = 1'b0;
  logic        iPush = 1'b0;
  logic        iPop = 1'b0;
  logic [15:0] iDataIn = '0;
  logic [15:0] oDataOut;
  logic        oDataValid, oFull, oEmpty;
  logic        oAlmostFull, oAlmostEmpty;
  logic [4:0]  oCount;
  logic        oOverflow, oUnderflow;

  sync_fifo_ctrl dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iClear       (iClear),
    .iPush        (iPush),
    .iDataIn      (iDataIn),
    .iPop         (iPop),
    .oDataOut     (oDataOut),
    .oDataValid   (oDataValid),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty),
    .oCount       (oCount),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst, clr, push, pop;
    logic [15:0] din;
    logic [4:0]  cnt;
    logic        full, empty, af, ae;
    logic        valid, ov, un;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[13];

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_dout = '0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic drive(logic r, logic c, logic p,
                       logic [15:0] d, logic q);
    Reset = r;
    iClear = c;
    iPush = p;
    iDataIn = d;
    iPop = q;
    @(posedge Clock);
    #1;
  endtask

  // flags for the default levels: AF at >=12, AE at <=2
  task automatic st(string nm, int cnt, logic v,
                    logic ov, logic un);
    chk({nm, ".cnt"}, 32'(oCount), 32'(cnt));
    chk({nm, ".full"}, 32'(oFull), 32'(cnt == 16));
    chk({nm, ".empty"}, 32'(oEmpty), 32'(cnt == 0));
    chk({nm, ".af"}, 32'(oAlmostFull), 32'(cnt >= 12));
    chk({nm, ".ae"}, 32'(oAlmostEmpty), 32'(cnt <= 2));
    chk({nm, ".valid"}, 32'(oDataValid), 32'(v));
    chk({nm, ".dout"}, 32'(oDataOut), 32'(exp_dout));
    chk({nm, ".ov"}, 32'(oOverflow), 32'(ov));
    chk({nm, ".un"}, 32'(oUnderflow), 32'(un));
  endtask

  task automatic push(logic [15:0] d);
    drive(0, 0, 1, d, 0);
  endtask

  task automatic pop();
    drive(0, 0, 0, '0, 1);
  endtask

  initial begin
    //        rst clr psh pop din      cnt f e af ae v ov un dout
    tbl[0]  = '{1, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[1]  = '{1, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[2]  = '{0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[3]  = '{0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[4]  = '{0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[5]  = '{0, 0, 1, 0, 16'hAAAA, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0};
    tbl[6]  = '{0, 0, 1, 0, 16'hBBBB, 2, 0, 0, 0, 1, 0, 0, 0, 16'h0};
    tbl[7]  = '{0, 0, 1, 0, 16'hCCCC, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0};
    tbl[8]  = '{0, 0, 0, 1, 16'h0,    2, 0, 0, 0, 1, 1, 0, 0, 16'hAAAA};
    tbl[9]  = '{0, 0, 0, 0, 16'h0,    2, 0, 0, 0, 1, 0, 0, 0, 16'hAAAA};
    tbl[10] = '{1, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};
    tbl[11] = '{0, 0, 0, 1, 16'h0,    0, 0, 1, 0, 1, 0, 0, 1, 16'h0};
    tbl[12] = '{0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 0, 0, 0, 16'h0};

    for (int i = 0; i < 13; i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].clr, tbl[i].push,
            tbl[i].din, tbl[i].pop);
      chk({n, ".cnt"}, 32'(oCount), 32'(tbl[i].cnt));
      chk({n, ".full"}, 32'(oFull), 32'(tbl[i].full));
      chk({n, ".empty"}, 32'(oEmpty), 32'(tbl[i].empty));
      chk({n, ".af"}, 32'(oAlmostFull), 32'(tbl[i].af));
      chk({n, ".ae"}, 32'(oAlmostEmpty), 32'(tbl[i].ae));
      chk({n, ".valid"}, 32'(oDataValid), 32'(tbl[i].valid));
      chk({n, ".ov"}, 32'(oOverflow), 32'(tbl[i].ov));
      chk({n, ".un"}, 32'(oUnderflow), 32'(tbl[i].un));
      chk({n, ".dout"}, 32'(oDataOut), 32'(tbl[i].dout));
    end
    exp_dout = '0;

    // fill to full, then overflow
    for (int i = 1; i <= 16; i++) begin
      push(16'(i));
      st($sformatf("fill%0d", i), i, 0, 0, 0);
    end
    push(16'hDEAD);
    st("ovf", 16, 0, 1, 0);
    drive(0, 0, 0, '0, 0);
    st("ovf_idle", 16, 0, 0, 0);

    // drain back-to-back, then underflow
    for (int i = 1; i <= 16; i++) begin
      pop();
      exp_dout = 16'(i);
      st($sformatf("drain%0d", i), 16 - i, 1, 0, 0);
    end
    pop();
    st("unf", 0, 0, 0, 1);
    drive(0, 0, 0, '0, 0);
    st("unf_idle", 0, 0, 0, 0);

    // pointer wrap-around
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    st("wrapA_fill", 10, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      pop();
      exp_dout = 16'h0100 + 16'(i);
      st($sformatf("wrapA%0d", i), 9 - i, 1, 0, 0);
    end
    for (int i = 0; i < 10; i++) push(16'h0A00 + 16'(i));
    st("wrapB_fill", 10, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      pop();
      exp_dout = 16'h0A00 + 16'(i);
      st($sformatf("wrapB%0d", i), 9 - i, 1, 0, 0);
    end

    // simultaneous push+pop at count 5
    for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
    drive(0, 0, 1, 16'h0055, 1);
    exp_dout = 16'h0050;
    st("both_mid", 5, 1, 0, 0);

    // fill 0x56..0x60, then push+pop at full
    for (int i = 0; i < 11; i++) push(16'h0056 + 16'(i));
    st("both_full_pre", 16, 0, 0, 0);
    drive(0, 0, 1, 16'hBEEF, 1);
    exp_dout = 16'h0051;
    st("both_full", 15, 1, 1, 0);
    for (int i = 0; i < 15; i++) begin
      pop();
      exp_dout = 16'h0052 + 16'(i);
      st($sformatf("drainB%0d", i), 14 - i, 1, 0, 0);
    end

    // simultaneous push+pop at empty
    drive(0, 0, 1, 16'h0077, 1);
    st("both_empty", 1, 0, 0, 1);
    pop();
    exp_dout = 16'h0077;
    st("both_empty_pop", 0, 1, 0, 0);

    // mid-stream reset at count 7
    for (int i = 0; i < 7; i++) push(16'h00B0 + 16'(i));
    st("rst_pre", 7, 0, 0, 0);
    drive(1, 0, 1, 16'hFFFF, 1);
    exp_dout = '0;
    st("rst_mid", 0, 0, 0, 0);
    push(16'h1234);
    pop();
    exp_dout = 16'h1234;
    st("rst_after", 0, 1, 0, 0);

    // mid-stream clear at count 7, requests ignored
    for (int i = 0; i < 8; i++) push(16'h00C0 + 16'(i));
    pop();
    exp_dout = 16'h00C0;
    st("clr_pre", 7, 1, 0, 0);
    drive(0, 1, 1, 16'hFFFF, 1);
    st("clr_mid", 0, 0, 0, 0);
    push(16'h1234);
    st("clr_push", 1, 0, 0, 0);
    pop();
    exp_dout = 16'h1234;
    st("clr_after", 0, 1, 0, 0);
    drive(0, 0, 0, '0, 0);
    st("final", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
